// File: rtl/pc_sequencer.sv
// Fetch/next-PC controller: owns the architectural PC and sequences IDLE -> FETCH -> EXEC.
// Latency: 2 cycles per instruction minimum, plus one per imem wait state and per stall cycle.
// Backpressure: FETCH holds while imem_ready=0; EXEC holds while stall=1; HALTED until rst.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        exc,
    input  logic        halt,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] epc,
    output logic        misaligned_err,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALTED = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] epc_q, epc_d;
    logic        mis_q, mis_d;

    logic [31:0] br_target;
    logic [31:0] j_target;

    // Redirect targets; the sequential add wraps naturally at 2^32.
    always_comb begin
        pc_plus4  = pc_q + 32'd4;
        br_target = pc_plus4 + {branch_offset[29:0], 2'b00};
        j_target  = {pc_plus4[31:28], jump_index, 2'b00};
    end

    // Next-state and outputs; redirects are only honoured in a non-stalled EXEC cycle.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        epc_d       = epc_q;
        mis_d       = mis_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                instr_valid = 1'b1;
                if (!stall) begin
                    state_d = ST_FETCH;
                    if (exc) begin
                        epc_d = pc_q;
                        pc_d  = EXC_VECTOR;
                    end else if (halt) begin
                        pc_d    = pc_plus4;
                        state_d = ST_HALTED;
                    end else if (jr) begin
                        if (jr_target[1:0] == 2'b00) begin
                            pc_d = jr_target;
                        end else begin
                            // Misaligned register target is turned into an exception.
                            mis_d = 1'b1;
                            epc_d = pc_q;
                            pc_d  = EXC_VECTOR;
                        end
                    end else if (jump) begin
                        pc_d = j_target;
                    end else if (branch_taken) begin
                        pc_d = br_target;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset discards any in-flight instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_VECTOR;
            epc_q   <= 32'h0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            mis_q   <= mis_d;
        end
    end

    assign imem_addr      = pc_q;
    assign pc             = pc_q;
    assign epc            = epc_q;
    assign misaligned_err = mis_q;
    assign state          = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, wait states, redirects, stall, halt, wrap.
// Inputs driven and outputs sampled on the falling edge.
// Expected values are hand-computed constants.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        instr_valid;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        jr;
    logic [31:0] jr_target;
    logic        exc;
    logic        halt;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] epc;
    logic        misaligned_err;
    logic [1:0]  state;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .instr_valid(instr_valid), .stall(stall),
        .branch_taken(branch_taken), .branch_offset(branch_offset),
        .jump(jump), .jump_index(jump_index),
        .jr(jr), .jr_target(jr_target),
        .exc(exc), .halt(halt),
        .pc(pc), .pc_plus4(pc_plus4), .epc(epc),
        .misaligned_err(misaligned_err), .state(state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic clr_redirects();
        branch_taken  = 1'b0;
        branch_offset = 32'h0;
        jump          = 1'b0;
        jump_index    = 26'h0;
        jr            = 1'b0;
        jr_target     = 32'h0;
        exc           = 1'b0;
        halt          = 1'b0;
    endtask

    // One instruction from FETCH (ready=1) through EXEC; redirect inputs set by caller.
    task automatic instr(input logic [31:0] exp_pc);
        chk("fetch_state", 32'(state), 32'd1);
        chk("fetch_addr", imem_addr, exp_pc);
        chk("fetch_req", 32'(imem_req), 32'd1);
        chk("fetch_valid", 32'(instr_valid), 32'd0);
        cyc();
        chk("exec_state", 32'(state), 32'd2);
        chk("exec_valid", 32'(instr_valid), 32'd1);
        chk("exec_req", 32'(imem_req), 32'd0);
        chk("exec_pc", pc, exp_pc);
        chk("exec_pc4", pc_plus4, exp_pc + 32'd4);
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        imem_ready = 1'b1;
        stall      = 1'b0;
        clr_redirects();
        cyc();
        cyc();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_epc", epc, 32'h0);
        chk("rst_mis", 32'(misaligned_err), 32'd0);
        rst        = 1'b0;
        imem_ready = 1'b0;
        cyc();
        // Three wait states then ready: four stable FETCH cycles at address 0.
        for (int i = 0; i < 4; i++) begin
            chk("wait_state", 32'(state), 32'd1);
            chk("wait_req", 32'(imem_req), 32'd1);
            chk("wait_addr", imem_addr, 32'h0);
            chk("wait_pc", pc, 32'h0);
            chk("wait_valid", 32'(instr_valid), 32'd0);
            if (i == 3) imem_ready = 1'b1;
            cyc();
        end
        chk("wait_exec_state", 32'(state), 32'd2);
        chk("wait_exec_valid", 32'(instr_valid), 32'd1);
        cyc();
        instr(32'h4);
        instr(32'h8);
        instr(32'hC);

        // Taken branch with offset -2 words: 0x14 - 8 = 0x0C.
        branch_taken = 1'b1; branch_offset = 32'hFFFF_FFFE;
        instr(32'h10);
        clr_redirects();
        chk("branch_pc", pc, 32'h0C);
        instr(32'h0C);
        jump = 1'b1; jump_index = 26'h40;
        instr(32'h10);
        clr_redirects();
        chk("jump_pc", pc, 32'h100);
        // Jump beats branch: 0x120 rather than 0x104+0x10.
        jump = 1'b1; jump_index = 26'h48; branch_taken = 1'b1; branch_offset = 32'h4;
        instr(32'h100);
        clr_redirects();
        chk("jump_over_branch", pc, 32'h120);

        jr = 1'b1; jr_target = 32'h20;
        instr(32'h120);
        clr_redirects();
        chk("jr_pc", pc, 32'h20);
        chk("jr_mis_clear", 32'(misaligned_err), 32'd0);
        jr = 1'b1; jr_target = 32'h2002;
        instr(32'h20);
        clr_redirects();
        chk("jr_mis_pc", pc, 32'h180);
        chk("jr_mis_epc", epc, 32'h20);
        chk("jr_mis_flag", 32'(misaligned_err), 32'd1);
        for (int i = 0; i < 10; i++) instr(32'h180 + 32'(i) * 32'd4);
        chk("mis_sticky", 32'(misaligned_err), 32'd1);
        chk("seq_after_mis", pc, 32'h1A8);
        jr = 1'b1; jr_target = 32'h2000;
        instr(32'h1A8);
        clr_redirects();
        chk("jr_aligned", pc, 32'h2000);

        // Stall holds PC and ignores exc/halt/jr; exc then taken when stall drops.
        jr = 1'b1; jr_target = 32'h40;
        instr(32'h2000);
        clr_redirects();
        chk("stall_fetch_addr", imem_addr, 32'h40);
        cyc();
        stall = 1'b1; exc = 1'b1; halt = 1'b1; jr = 1'b1; jr_target = 32'h3;
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("stall_state", 32'(state), 32'd2);
            chk("stall_pc", pc, 32'h40);
            chk("stall_epc", epc, 32'h20);
        end
        stall = 1'b0; halt = 1'b0; jr = 1'b0;
        cyc();
        clr_redirects();
        chk("exc_pc", pc, 32'h180);
        chk("exc_epc", epc, 32'h40);
        chk("exc_state", 32'(state), 32'd1);

        // Halt at 0x50: PC advances once, then frozen.
        jr = 1'b1; jr_target = 32'h50;
        instr(32'h180);
        clr_redirects();
        halt = 1'b1;
        instr(32'h50);
        clr_redirects();
        for (int i = 0; i < 3; i++) begin
            chk("halt_state", 32'(state), 32'd3);
            chk("halt_pc", pc, 32'h54);
            chk("halt_req", 32'(imem_req), 32'd0);
            chk("halt_valid", 32'(instr_valid), 32'd0);
            cyc();
        end

        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("unhalt_state", 32'(state), 32'd0);
        cyc();
        jr = 1'b1; jr_target = 32'h60;
        instr(32'h0);
        clr_redirects();
        cyc();
        stall = 1'b1;
        cyc();
        chk("pre_rst_pc", pc, 32'h60);
        rst = 1'b1;
        cyc();
        rst = 1'b0; stall = 1'b0;
        chk("midstall_rst_pc", pc, 32'h0);
        chk("midstall_rst_state", 32'(state), 32'd0);
        chk("midstall_rst_epc", epc, 32'h0);
        chk("midstall_rst_mis", 32'(misaligned_err), 32'd0);
        cyc();

        // Sequential wrap at the top of the address space.
        jr = 1'b1; jr_target = 32'hFFFF_FFFC;
        instr(32'h0);
        clr_redirects();
        instr(32'hFFFF_FFFC);
        chk("wrap_pc", pc, 32'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
